// File: rtl/inst_loader_if.sv
// -----------------------------------------------------------------------------
// inst_loader_if
// Byte-stream input and instruction-memory write bus of the instruction loader.
//
//   ByteIn    [7:0]        incoming stream byte
//   ByteValid              ByteIn is valid
//   ByteReady              loader accepts a byte this cycle
//   WrEn                   one-cycle word-write strobe
//   WrAddr    [ADDR_W-1:0] byte address of the written word (multiple of 4)
//   WrData    [31:0]       assembled little-endian word
//
// Modports:
//   master : host side, which sources bytes and observes memory writes
//   slave  : loader side
// -----------------------------------------------------------------------------
interface inst_loader_if #(
  parameter int ADDR_W = 7
);
  logic [7:0]        ByteIn;
  logic              ByteValid;
  logic              ByteReady;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [31:0]       WrData;

  modport master (
    output ByteIn, ByteValid,
    input  ByteReady, WrEn, WrAddr, WrData
  );

  modport slave (
    input  ByteIn, ByteValid,
    output ByteReady, WrEn, WrAddr, WrData
  );
endinterface

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Loads a program into a writable instruction memory from a byte stream.
// Stream format: one length byte N (1..MAX_WORDS), then 4*N data bytes, each
// word little-endian. Every completed word is written with a one-cycle WrEn
// strobe at byte address 4*index. The core is held in reset (CpuHold) while a
// session is active. Done / Error report the session outcome and persist until
// the next Start or reset.
//
// Optional feature macro: INST_LOADER_CHECKSUM_EN
//   When defined, one trailing checksum byte (XOR of all data bytes) is checked
//   after the last word; a mismatch ends in Error. Written words stay written.
//
// Ports:
//   CLK      clock, rising edge
//   RSTN     asynchronous active-low reset
//   Start    single-cycle session request (honoured in IDLE, DONE, ERR)
//   bus      inst_loader_if.slave: byte stream in, word-write bus out
//   CpuHold  core reset hold while a session is active or a write is issued
//   Done     session completed successfully
//   Error    session aborted
// -----------------------------------------------------------------------------
module inst_loader #(
  parameter int MAX_WORDS = 32,
  parameter int ADDR_W    = 7
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         Start,
  inst_loader_if.slave bus,
  output logic         CpuHold,
  output logic         Done,
  output logic         Error
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    DONE,
    ERR
`ifdef INST_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;        // bytes 0..2 of the word in progress
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif
  logic              busy;
  logic              accept;

  always_comb begin
    busy = (state_q == LEN) || (state_q == LOAD);
`ifdef INST_LOADER_CHECKSUM_EN
    busy = busy || (state_q == CHK);
`endif
  end

  assign accept        = busy && bus.ByteValid;
  assign bus.ByteReady = busy;
  assign bus.WrEn      = wr_en_q;
  assign bus.WrAddr    = wr_addr_q;
  assign bus.WrData    = wr_data_q;
  // The write strobe lands one cycle after the last byte, possibly already in
  // DONE, so the hold has to cover that cycle too.
  assign CpuHold       = busy || wr_en_q;
  assign Done          = (state_q == DONE);
  assign Error         = (state_q == ERR);

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef INST_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif

    case (state_q)
      IDLE, DONE, ERR: begin
        if (Start) begin
          state_d    = LEN;
          word_cnt_d = '0;
          byte_cnt_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
          xor_d      = '0;
`endif
        end
      end

      LEN: begin
        if (accept) begin
          if (bus.ByteIn == 8'd0 || int'(bus.ByteIn) > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            len_d   = CNT_W'(bus.ByteIn);
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ bus.ByteIn;
`endif
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = bus.ByteIn;
            2'd1: asm_d[15:8]  = bus.ByteIn;
            2'd2: asm_d[23:16] = bus.ByteIn;
            default: begin
              // Fourth byte completes the word; it goes straight into the
              // output register so WrData is valid with the strobe.
              wr_en_d    = 1'b1;
              wr_addr_d  = ADDR_W'({word_cnt_q, 2'b00});
              wr_data_d  = {bus.ByteIn, asm_q};
              word_cnt_d = word_cnt_q + CNT_W'(1);
              if (word_cnt_q == len_q - CNT_W'(1)) begin
`ifdef INST_LOADER_CHECKSUM_EN
                state_d = CHK;
`else
                state_d = DONE;
`endif
              end
            end
          endcase
        end
      end

`ifdef INST_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = (bus.ByteIn == xor_q) ? DONE : ERR;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef INST_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

endmodule
